// File: rtl/pong_field_engine.sv
// Frame-synchronous ball/paddle state for the Pong display path: paddles, ball bounces, points, serve.
// Define PONG_SCORE_EN to add p1_score/p2_score, the WIN_SCORE parameter and the GAMEOVER state.
module pong_field_engine #(
    parameter int COORD_W      = 11,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int BALL_SIZE    = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int HOLD_FRAMES  = 60
`ifdef PONG_SCORE_EN
    , parameter int WIN_SCORE  = 9
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    input  logic               serve,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] p1_y,
    output logic [COORD_W-1:0] p2_y,
    output logic [1:0]         state,
    output logic               point_p1,
    output logic               point_p2
`ifdef PONG_SCORE_EN
    , output logic [3:0]       p1_score
    , output logic [3:0]       p2_score
`endif
);
    localparam int W     = COORD_W + 1;
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    typedef logic [W-1:0]       wide_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t BALL_X0 = coord_t'((SCREEN_W - BALL_SIZE) / 2);
    localparam coord_t BALL_Y0 = coord_t'((SCREEN_H - BALL_SIZE) / 2);
    localparam coord_t PAD_Y0  = coord_t'((SCREEN_H - PADDLE_H) / 2);
    localparam wide_t  PS      = wide_t'(PADDLE_SPEED);
    localparam wide_t  PAD_MAX = wide_t'(SCREEN_H - PADDLE_H);
    localparam wide_t  BS      = wide_t'(BALL_SPEED);
    localparam wide_t  BSZ     = wide_t'(BALL_SIZE);
    localparam wide_t  PH      = wide_t'(PADDLE_H);
    localparam wide_t  Y_MAX   = wide_t'(SCREEN_H - BALL_SIZE);
    localparam wide_t  X_EDGE  = wide_t'(SCREEN_W);
    localparam wide_t  R_FACE  = wide_t'(P2_X);
    localparam wide_t  L_FACE  = wide_t'(P1_X + PADDLE_W);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, SCORED = 2'd2, GAMEOVER = 2'd3} state_t;

    state_t           st;
    logic             dx_neg, dy_neg;
    logic [CNT_W-1:0] hold_cnt;

    coord_t nx, ny;
    logic   ndx, ndy, ov1, ov2, r_cross, l_cross, hit_r, hit_l, miss_r, miss_l;
    logic   win_p1, win_p2;
    wide_t  bxw, byw, p1w, p2w;

    assign state = st;

    function automatic coord_t paddle_next(input coord_t y, input logic up, input logic dn);
        wide_t yw;
        yw = wide_t'(y);
        if (up && !dn) begin
            if (yw < PS) return '0;
            return coord_t'(yw - PS);
        end
        if (dn && !up) begin
            if (yw + PS > PAD_MAX) return coord_t'(PAD_MAX);
            return coord_t'(yw + PS);
        end
        return y;
    endfunction

    // Next ball position, resolved y first then x, all from pre-tick registers.
    always_comb begin
        bxw = wide_t'(ball_x);
        byw = wide_t'(ball_y);
        p1w = wide_t'(p1_y);
        p2w = wide_t'(p2_y);

        if (dy_neg) begin
            if (byw < BS) begin ny = '0; ndy = 1'b0; end
            else          begin ny = coord_t'(byw - BS); ndy = 1'b1; end
        end else if (byw + BS > Y_MAX) begin
            ny = coord_t'(Y_MAX); ndy = 1'b1;
        end else begin
            ny = coord_t'(byw + BS); ndy = 1'b0;
        end

        ov1     = (byw + BSZ > p1w) && (byw < p1w + PH);
        ov2     = (byw + BSZ > p2w) && (byw < p2w + PH);
        r_cross = !dx_neg && (bxw + BSZ <= R_FACE) && (bxw + BSZ + BS > R_FACE);
        l_cross =  dx_neg && (bxw >= L_FACE) && (bxw < L_FACE + BS);
        hit_r   = r_cross && ov2;
        hit_l   = l_cross && ov1;
        // A ball crossing a paddle face without overlap is lost on that frame.
        miss_r  = (r_cross && !ov2) || (!hit_r && (bxw + BSZ + BS > X_EDGE));
        miss_l  = (l_cross && !ov1) || (!hit_l && (bxw < BS));

        ndx = dx_neg;
        if (hit_r) begin
            nx = coord_t'(R_FACE - BSZ); ndx = 1'b1;
        end else if (hit_l) begin
            nx = coord_t'(L_FACE); ndx = 1'b0;
        end else if (dx_neg) begin
            nx = (bxw < BS) ? '0 : coord_t'(bxw - BS);
        end else begin
            nx = coord_t'(bxw + BS);
        end

`ifdef PONG_SCORE_EN
        win_p1 = (p1_score == 4'(WIN_SCORE - 1));
        win_p2 = (p2_score == 4'(WIN_SCORE - 1));
`else
        win_p1 = 1'b0;
        win_p2 = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            ball_x   <= BALL_X0;
            ball_y   <= BALL_Y0;
            p1_y     <= PAD_Y0;
            p2_y     <= PAD_Y0;
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b0;
            hold_cnt <= '0;
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
`ifdef PONG_SCORE_EN
            p1_score <= '0;
            p2_score <= '0;
`endif
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            if (frame_tick) begin
                p1_y <= paddle_next(p1_y, p1_up, p1_down);
                p2_y <= paddle_next(p2_y, p2_up, p2_down);
            end
            case (st)
                IDLE: begin
                    ball_x <= BALL_X0;
                    ball_y <= BALL_Y0;
                    if (serve) st <= PLAY;
                end
                PLAY: if (frame_tick) begin
                    if (miss_r || miss_l) begin
                        // Next serve heads toward whoever conceded.
                        point_p1 <= miss_r;
                        point_p2 <= !miss_r;
                        dx_neg   <= !miss_r;
                        dy_neg   <= 1'b0;
`ifdef PONG_SCORE_EN
                        if (miss_r) p1_score <= p1_score + 4'd1;
                        else        p2_score <= p2_score + 4'd1;
`endif
                        if (miss_r ? win_p1 : win_p2) begin
                            st     <= GAMEOVER;
                            ball_x <= BALL_X0;
                            ball_y <= BALL_Y0;
                        end else begin
                            st <= SCORED;
                        end
                    end else begin
                        ball_x <= nx;
                        ball_y <= ny;
                        dx_neg <= ndx;
                        dy_neg <= ndy;
                    end
                end
                SCORED: if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        ball_x   <= BALL_X0;
                        ball_y   <= BALL_Y0;
                        st       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAMEOVER: begin
`ifdef PONG_SCORE_EN
                    if (serve) begin
                        p1_score <= '0;
                        p2_score <= '0;
                        st       <= IDLE;
                    end
`else
                    st <= IDLE;
`endif
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_field_engine.sv
// Scoreboard bench for pong_field_engine: expected snapshots queued per tick, popped after each tick.
// Scoring checks are compiled only when PONG_SCORE_EN is defined.
module tb_pong_field_engine;
    logic clock = 1'b0;
    logic reset, frame_tick, p1_up, p1_down, p2_up, p2_down, serve;
    logic [10:0] ball_x, ball_y, p1_y, p2_y;
    logic [1:0]  state;
    logic        point_p1, point_p2;
`ifdef PONG_SCORE_EN
    logic [3:0]  p1_score, p2_score;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          tick;
        string       name;
        logic [47:0] val;
        logic [47:0] mask;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    pong_field_engine dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .serve(serve), .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
        .state(state), .point_p1(point_p1), .point_p2(point_p2)
`ifdef PONG_SCORE_EN
        , .p1_score(p1_score), .p2_score(p2_score)
`endif
    );

    always #5 clock = ~clock;

    // Negative field values mean "don't care".
    function automatic exp_t mk(int t, string nm, int bx, int by, int p1, int p2, int st, int pp1, int pp2);
        exp_t x;
        x.tick = t; x.name = nm; x.val = '0; x.mask = '0;
        if (bx  >= 0) begin x.val[47:37] = 11'(bx); x.mask[47:37] = '1; end
        if (by  >= 0) begin x.val[36:26] = 11'(by); x.mask[36:26] = '1; end
        if (p1  >= 0) begin x.val[25:15] = 11'(p1); x.mask[25:15] = '1; end
        if (p2  >= 0) begin x.val[14:4]  = 11'(p2); x.mask[14:4]  = '1; end
        if (st  >= 0) begin x.val[3:2]   = 2'(st);  x.mask[3:2]   = '1; end
        if (pp1 >= 0) begin x.val[1]     = 1'(pp1); x.mask[1]     = 1'b1; end
        if (pp2 >= 0) begin x.val[0]     = 1'(pp2); x.mask[0]     = 1'b1; end
        return x;
    endfunction

    function automatic logic [47:0] obs();
        return {ball_x, ball_y, p1_y, p2_y, state, point_p1, point_p2};
    endfunction

    function automatic string show(logic [47:0] v);
        return $sformatf("bx=%0d by=%0d p1=%0d p2=%0d st=%0d pt=%b%b",
                         v[47:37], v[36:26], v[25:15], v[14:4], v[3:2], v[1], v[0]);
    endfunction

    task automatic do_reset();
        {frame_tick, p1_up, p1_down, p2_up, p2_down, serve} = '0;
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clock); #1 frame_tick = 1'b0;
    endtask

    task automatic do_serve();
        serve = 1'b1;
        @(posedge clock); #1 serve = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sb.delete();
        sb.push_back(mk(0, "reset_vals", 316, 236, 208, 208, 0, 0, 0));
        while (sb.size() > 0 && sb[0].tick == 0) begin
            e = sb.pop_front(); tests++;
            if ((obs() & e.mask) !== e.val) begin
                fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
            end
        end
    endtask

    task automatic test_paddle();
        do_reset();
        sb.delete();
        p1_up = 1'b1; p2_down = 1'b1;
        sb.push_back(mk(1,  "p1_first_step", -1, -1, 204, 212, 0, -1, -1));
        sb.push_back(mk(51, "p1_near_top",   -1, -1, 4,   412, -1, -1, -1));
        sb.push_back(mk(52, "p1_top",        -1, -1, 0,   416, -1, -1, -1));
        sb.push_back(mk(60, "p1_stay_top",   316, 236, 0, 416, 0, 0, 0));
        sb.push_back(mk(61, "p1_both_hold",  -1, -1, 0,   -1, -1, -1, -1));
        sb.push_back(mk(64, "p1_both_hold2", -1, -1, 0,   416, -1, -1, -1));
        for (int n = 1; n <= 64; n++) begin
            if (n == 61) p1_down = 1'b1;
            tick();
            while (sb.size() > 0 && sb[0].tick == n) begin
                e = sb.pop_front(); tests++;
                if ((obs() & e.mask) !== e.val) begin
                    fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
                end
            end
        end
        p1_up = 1'b0; p1_down = 1'b0; p2_down = 1'b0;
    endtask

    task automatic test_serve_wall();
        do_reset();
        sb.delete();
        sb.push_back(mk(0,   "serve_same_tick", 316, 236, -1, -1, 1, 0, 0));
        sb.push_back(mk(1,   "first_move",      318, 238, 208, 208, 1, 0, 0));
        sb.push_back(mk(118, "bottom_reach",    552, 472, -1, -1, 1, -1, -1));
        sb.push_back(mk(119, "bottom_flip",     554, 472, -1, -1, 1, -1, -1));
        sb.push_back(mk(120, "bottom_leave",    556, 470, -1, -1, 1, -1, -1));
        serve = 1'b1; frame_tick = 1'b1;
        @(posedge clock); #1 serve = 1'b0; frame_tick = 1'b0;
        for (int n = 0; n <= 120; n++) begin
            if (n > 0) tick();
            while (sb.size() > 0 && sb[0].tick == n) begin
                e = sb.pop_front(); tests++;
                if ((obs() & e.mask) !== e.val) begin
                    fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
                end
            end
        end
    endtask

    task automatic test_paddle_hit();
        do_reset();
        sb.delete();
        p2_down = 1'b1;
        repeat (52) tick();
        do_serve();
        sb.push_back(mk(0,   "hit_pre_serve", 316, 236, -1, 416, 1, -1, -1));
        sb.push_back(mk(146, "hit_approach",  608, 418, -1, 416, 1, 0, 0));
        sb.push_back(mk(147, "hit_bounce",    608, 416, -1, 416, 1, 0, 0));
        sb.push_back(mk(148, "hit_leave",     606, 414, -1, 416, 1, 0, 0));
        for (int n = 0; n <= 148; n++) begin
            if (n > 0) tick();
            while (sb.size() > 0 && sb[0].tick == n) begin
                e = sb.pop_front(); tests++;
                if ((obs() & e.mask) !== e.val) begin
                    fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
                end
            end
        end
        p2_down = 1'b0;
    endtask

    task automatic test_miss_hold();
        do_reset();
        sb.delete();
        do_serve();
        sb.push_back(mk(146, "miss_approach",  608, 418, -1, -1, 1, 0, 0));
        sb.push_back(mk(147, "miss_point",     608, 418, -1, -1, 2, 1, 0));
        sb.push_back(mk(148, "miss_pulse_end", 608, 418, -1, -1, 2, 0, 0));
        sb.push_back(mk(150, "serve_ignored",  608, 418, -1, -1, 2, 0, 0));
        sb.push_back(mk(206, "hold_frozen",    608, 418, -1, -1, 2, 0, 0));
        sb.push_back(mk(207, "hold_recentre",  316, 236, -1, -1, 0, 0, 0));
        for (int n = 1; n <= 207; n++) begin
            if (n == 150) serve = 1'b1;
            tick();
            serve = 1'b0;
            while (sb.size() > 0 && sb[0].tick == n) begin
                e = sb.pop_front(); tests++;
                if ((obs() & e.mask) !== e.val) begin
                    fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
                end
            end
        end
        do_serve();
        sb.push_back(mk(1, "reserve_plus_x", 318, 238, -1, -1, 1, 0, 0));
        tick();
        while (sb.size() > 0 && sb[0].tick == 1) begin
            e = sb.pop_front(); tests++;
            if ((obs() & e.mask) !== e.val) begin
                fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb.delete();
        do_serve();
        p1_down = 1'b1; p2_up = 1'b1;
        sb.push_back(mk(42, "midplay_pos", 400, 320, 376, 40, 1, 0, 0));
        for (int n = 1; n <= 42; n++) begin
            tick();
            while (sb.size() > 0 && sb[0].tick == n) begin
                e = sb.pop_front(); tests++;
                if ((obs() & e.mask) !== e.val) begin
                    fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
                end
            end
        end
        p1_down = 1'b0; p2_up = 1'b0;
        sb.push_back(mk(0, "async_reset", 316, 236, 208, 208, 0, 0, 0));
        @(negedge clock); #2 reset = 1'b1;
        #1;
        while (sb.size() > 0 && sb[0].tick == 0) begin
            e = sb.pop_front(); tests++;
            if ((obs() & e.mask) !== e.val) begin
                fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
            end
        end
        @(posedge clock); #1 reset = 1'b0;
    endtask

`ifdef PONG_SCORE_EN
    task automatic test_scoring();
        do_reset();
        sb.delete();
        for (int r = 1; r <= 9; r++) begin
            do_serve();
            repeat (147) tick();
            tests++;
            if (p1_score !== 4'(r) || p2_score !== 4'd0) begin
                fails++; $display("FAIL score_round_%0d: got p1=%0d p2=%0d want p1=%0d p2=0", r, p1_score, p2_score, r);
            end
            if (r < 9) repeat (60) tick();
        end
        sb.push_back(mk(0, "gameover", 316, 236, -1, -1, 3, 1, 0));
        while (sb.size() > 0 && sb[0].tick == 0) begin
            e = sb.pop_front(); tests++;
            if ((obs() & e.mask) !== e.val) begin
                fails++; $display("FAIL %s: got %s want %s", e.name, show(obs()), show(e.val));
            end
        end
        do_serve();
        tests++;
        if (p1_score !== 4'd0 || p2_score !== 4'd0 || state !== 2'd0) begin
            fails++; $display("FAIL gameover_serve: got p1=%0d p2=%0d st=%0d want 0 0 0", p1_score, p2_score, state);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        {frame_tick, p1_up, p1_down, p2_up, p2_down, serve} = '0;
        test_reset();
        test_paddle();
        test_serve_wall();
        test_paddle_hit();
        test_miss_hold();
        test_reset_mid();
`ifdef PONG_SCORE_EN
        test_scoring();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
